// File: rtl/ts_sync_pkg.sv
// Shared types and defaults for MPEG-2 TS sync recovery.
// Optional flywheel loss tolerance is enabled by defining TS_SYNC_FLYWHEEL_EN.
package ts_sync_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } ts_state_e;

    localparam int          DEF_PKT_LEN   = 188;
    localparam logic [7:0]  DEF_SYNC_BYTE = 8'h47;
    localparam int          CNT_W         = 8;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/ts_pos_counter.sv
// Modulo-PKT_LEN byte position counter: 1-cycle registered update, advances only when enabled.
// Clear beats load-to-1, which beats the advance.
module ts_pos_counter #(
    parameter int PKT_LEN = 188,
    parameter int POS_W   = $clog2(PKT_LEN)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load_one,
    input  logic clr,
    output logic pos_zero
);

    logic [POS_W-1:0] pos;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pos <= '0;
        end else if (load_one) begin
            pos <= POS_W'(1);
        end else if (en) begin
            pos <= (pos == POS_W'(PKT_LEN - 1)) ? '0 : pos + POS_W'(1);
        end
    end

    assign pos_zero = (pos == '0);

endmodule

// File: rtl/ts_sync_module.sv
// TS sync hunt/verify/lock for one byte lane; byte_out and valid_packet are 1 cycle after byte_in, no back-pressure.
// Define TS_SYNC_FLYWHEEL_EN to tolerate up to LOSS_COUNT-1 consecutive missed syncs while locked.
module ts_sync_module
    import ts_sync_pkg::*;
#(
    parameter int          PKT_LEN    = DEF_PKT_LEN,
    parameter logic [7:0]  SYNC_BYTE  = DEF_SYNC_BYTE,
    parameter int          LOCK_COUNT = 3,
    parameter int          LOSS_COUNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       valid_packet,
    output logic [7:0] byte_out
);

    if (LOCK_COUNT < 2 || LOCK_COUNT > 255) begin : g_lock_range
        $error("LOCK_COUNT must be within 2..255");
    end
    if (LOSS_COUNT < 1 || LOSS_COUNT > 255) begin : g_loss_range
        $error("LOSS_COUNT must be within 1..255");
    end

    localparam logic [CNT_W-1:0] LOCK_TH = CNT_W'(LOCK_COUNT);

    ts_state_e        state, state_d;
    logic [CNT_W-1:0] good_cnt, good_d, good_next;
    logic             is_sync, pos_zero;
    logic             go_hunt, load_one, pulse;

    assign is_sync   = (byte_in == SYNC_BYTE);
    assign good_next = sat_inc(good_cnt);

`ifdef TS_SYNC_FLYWHEEL_EN
    localparam logic [CNT_W-1:0] LOSS_TH = CNT_W'(LOSS_COUNT);
    logic [CNT_W-1:0] miss_cnt, miss_d, miss_next;
    assign miss_next = sat_inc(miss_cnt);
`endif

    ts_pos_counter #(
        .PKT_LEN (PKT_LEN)
    ) u_pos (
        .clk      (clk),
        .rst      (rst),
        .en       (byte_valid && (state != HUNT)),
        .load_one (load_one),
        .clr      (go_hunt),
        .pos_zero (pos_zero)
    );

    always_comb begin
        state_d  = state;
        good_d   = good_cnt;
        go_hunt  = 1'b0;
        load_one = 1'b0;
        pulse    = 1'b0;
`ifdef TS_SYNC_FLYWHEEL_EN
        miss_d   = miss_cnt;
`endif
        if (byte_valid) begin
            case (state)
                HUNT: begin
                    if (is_sync) begin
                        state_d  = VERIFY;
                        good_d   = CNT_W'(1);
                        load_one = 1'b1;
                    end
                end
                VERIFY: begin
                    if (pos_zero) begin
                        if (is_sync) begin
                            good_d = good_next;
                            if (good_next >= LOCK_TH) begin
                                state_d = LOCKED;
                                pulse   = 1'b1;
`ifdef TS_SYNC_FLYWHEEL_EN
                                miss_d  = '0;
`endif
                            end
                        end else begin
                            go_hunt = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (pos_zero) begin
                        if (is_sync) begin
                            good_d = good_next;
                            pulse  = 1'b1;
`ifdef TS_SYNC_FLYWHEEL_EN
                            miss_d = '0;
`endif
                        end else begin
`ifdef TS_SYNC_FLYWHEEL_EN
                            // Keep flywheeling on pos until the miss budget is spent.
                            miss_d = miss_next;
                            if (miss_next >= LOSS_TH) begin
                                go_hunt = 1'b1;
                            end
`else
                            go_hunt = 1'b1;
`endif
                        end
                    end
                end
                default: go_hunt = 1'b1;
            endcase
        end
        if (go_hunt) begin
            state_d = HUNT;
            good_d  = '0;
`ifdef TS_SYNC_FLYWHEEL_EN
            miss_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HUNT;
            good_cnt     <= '0;
            valid_packet <= 1'b0;
            byte_out     <= 8'h00;
`ifdef TS_SYNC_FLYWHEEL_EN
            miss_cnt     <= '0;
`endif
        end else begin
            state        <= state_d;
            good_cnt     <= good_d;
            valid_packet <= pulse;
`ifdef TS_SYNC_FLYWHEEL_EN
            miss_cnt     <= miss_d;
`endif
            if (byte_valid) begin
                byte_out <= byte_in;
            end
        end
    end

endmodule

// File: tb/tb_ts_sync_module.sv
// Randomized bench for ts_sync_module against a stream-index alignment model.
// Builds with or without TS_SYNC_FLYWHEEL_EN.
module tb_ts_sync_module;

    localparam int         PKT_LEN    = 188;
    localparam int         LOCK_COUNT = 3;
    localparam int         LOSS_COUNT = 3;
    localparam logic [7:0] SYNC       = 8'h47;
`ifdef TS_SYNC_FLYWHEEL_EN
    localparam bit FLY = 1'b1;
`else
    localparam bit FLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       valid_packet;
    logic [7:0] byte_out;

    always #5 clk = ~clk;

    ts_sync_module #(
        .PKT_LEN    (PKT_LEN),
        .SYNC_BYTE  (SYNC),
        .LOCK_COUNT (LOCK_COUNT),
        .LOSS_COUNT (LOSS_COUNT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .valid_packet (valid_packet),
        .byte_out     (byte_out)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: alignment is an anchor index into the valid-byte stream; sync slots are anchor + k*PKT_LEN.
    bit         m_track, m_locked;
    int         m_anchor, m_vidx, m_good, m_miss;
    bit         exp_vp;
    logic [7:0] exp_bo;

    bit         chk_en = 1'b0;
    int         cyc, first_pulse, pulse_cnt;
    logic [7:0] bo_at_first;

    function automatic void model_edge();
        if (rst) begin
            m_track = 1'b0; m_locked = 1'b0; m_good = 0; m_miss = 0;
            exp_vp = 1'b0; exp_bo = 8'h00;
            return;
        end
        exp_vp = 1'b0;
        if (!byte_valid) return;
        exp_bo = byte_in;
        if (!m_track) begin
            if (byte_in == SYNC) begin
                m_track = 1'b1; m_locked = 1'b0; m_anchor = m_vidx; m_good = 1; m_miss = 0;
            end
        end else if (((m_vidx - m_anchor) % PKT_LEN) == 0) begin
            if (byte_in == SYNC) begin
                m_good++;
                m_miss = 0;
                if (m_locked || m_good >= LOCK_COUNT) begin
                    m_locked = 1'b1;
                    exp_vp = 1'b1;
                end
            end else if (!m_locked) begin
                m_track = 1'b0;
            end else begin
                m_miss++;
                if (!FLY || m_miss >= LOSS_COUNT) begin
                    m_track = 1'b0; m_locked = 1'b0;
                end
            end
        end
        m_vidx++;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (valid_packet !== exp_vp || byte_out !== exp_bo) begin
                n_err++;
                if (n_err < 30)
                    $display("FAIL outputs cyc=%0d valid_packet=%b want %b byte_out=%h want %h",
                             cyc, valid_packet, exp_vp, byte_out, exp_bo);
            end
            if (valid_packet === 1'b1) begin
                pulse_cnt++;
                if (first_pulse < 0) begin
                    first_pulse = cyc;
                    bo_at_first = byte_out;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pay();
        logic [7:0] x;
        x = 8'($urandom);
        if (x == SYNC) x = 8'h46;
        if (x == 8'h00) x = 8'h5A;
        return x;
    endfunction

    task automatic step(input logic [7:0] b, input bit v, input bit r);
        @(negedge clk);
        byte_in = b; byte_valid = v; rst = r;
        @(posedge clk);
        model_edge();
        cyc++;
    endtask

    task automatic do_reset();
        step(pay(), 1'b1, 1'b1);
        step(pay(), 1'b0, 1'b1);
        chk_en = 1'b1;
    endtask

    task automatic begin_seg();
        cyc = 0; first_pulse = -1; pulse_cnt = 0; bo_at_first = 8'h00;
    endtask

    task automatic send_pkts(input int n, input int corrupt_mask, input bit p47, input bit gaps);
        int vcount = 0;
        for (int p = 0; p < n; p++) begin
            for (int o = 0; o < PKT_LEN; o++) begin
                logic [7:0] b;
                if (o == 0)              b = corrupt_mask[p] ? 8'h00 : SYNC;
                else if (p47 && o == 50) b = SYNC;
                else                     b = pay();
                step(b, 1'b1, 1'b0);
                vcount++;
                if (gaps && (vcount % 40) == 0)
                    for (int g = 0; g < 5; g++) step(pay(), 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        int ph;
        m_vidx = 0; m_track = 1'b0; m_locked = 1'b0;
        exp_vp = 1'b0; exp_bo = 8'h00;
        begin_seg();

        // Clean lock
        do_reset();
        check("reset_valid_packet", int'(valid_packet), 0);
        check("reset_byte_out", int'(byte_out), 0);
        begin_seg();
        send_pkts(5, 0, 1'b0, 1'b0);
        check("lock_first_pulse_cycle", first_pulse, 377);
        check("lock_first_pulse_byte", int'(bo_at_first), 8'h47);
        check("lock_pulse_count", pulse_cnt, 3);

        // False sync then real packets at 300
        do_reset();
        begin_seg();
        step(SYNC, 1'b1, 1'b0);
        for (int i = 1; i < 300; i++) step((i == 188) ? 8'h12 : pay(), 1'b1, 1'b0);
        send_pkts(3, 0, 1'b0, 1'b0);
        check("false_sync_first_pulse", first_pulse, 677);
        check("false_sync_pulse_count", pulse_cnt, 1);

        // Payload 0x47 is ignored
        do_reset();
        begin_seg();
        send_pkts(6, 0, 1'b1, 1'b0);
        check("payload47_pulse_count", pulse_cnt, 4);

        // Single miss, then three consecutive misses
        do_reset();
        begin_seg();
        send_pkts(14, (1 << 4) | (1 << 8) | (1 << 9) | (1 << 10), 1'b0, 1'b0);
        check("miss_pulse_count", pulse_cnt, FLY ? 6 : 4);

        // Gaps every 40 valid bytes
        do_reset();
        begin_seg();
        send_pkts(5, 0, 1'b0, 1'b1);
        check("gap_first_pulse_cycle", first_pulse, 422);
        check("gap_pulse_count", pulse_cnt, 3);

        // Reset mid-packet while locked
        do_reset();
        send_pkts(3, 0, 1'b0, 1'b0);
        step(SYNC, 1'b1, 1'b0);
        for (int i = 1; i < 90; i++) step(pay(), 1'b1, 1'b0);
        step(pay(), 1'b1, 1'b1);
        #1;
        check("midrst_valid_packet", int'(valid_packet), 0);
        check("midrst_byte_out", int'(byte_out), 0);
        step(pay(), 1'b1, 1'b1);
        for (int i = 0; i < 98; i++) step(pay(), 1'b1, 1'b0);
        begin_seg();
        send_pkts(4, 0, 1'b0, 1'b0);
        check("relock_first_pulse", first_pulse, 377);
        check("relock_pulse_count", pulse_cnt, 2);

        // Randomized stream with corrupt syncs, stray 0x47, phase jumps, gaps and resets
        do_reset();
        begin_seg();
        ph = 0;
        for (int i = 0; i < 8000; i++) begin
            bit r, v;
            logic [7:0] b;
            r = ($urandom_range(0, 1999) == 0);
            v = ($urandom_range(0, 99) < 85);
            if (ph == 0) b = ($urandom_range(0, 9) == 0) ? pay() : SYNC;
            else         b = ($urandom_range(0, 99) == 0) ? SYNC : pay();
            step(b, v, r);
            if (v) begin
                if ($urandom_range(0, 499) == 0) ph = $urandom_range(0, PKT_LEN - 1);
                else                              ph = (ph + 1) % PKT_LEN;
            end
        end
        check("random_saw_pulses", int'(pulse_cnt > 0), 1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
